// File: rtl/ram_march_pkg.sv
// State type and per-element behaviour table for the RAM march tester.
// Each march element is described by direction, compare, write and polarity flags.
package ram_march_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StM0,
    StM1,
    StM2,
    StM3,
    StDone
  } state_e;

  typedef struct packed {
    logic active;   // element drives the RAM
    logic up;       // address direction
    logic cmp;      // read data is checked
    logic we;       // element writes
    logic wr_inv;   // write ~P instead of P
    logic exp_inv;  // expect ~P instead of P
  } elem_cfg_t;

  localparam elem_cfg_t ElemNone = '{active: 1'b0, up: 1'b0, cmp: 1'b0, we: 1'b0,
                                     wr_inv: 1'b0, exp_inv: 1'b0};
  localparam elem_cfg_t ElemM0   = '{active: 1'b1, up: 1'b1, cmp: 1'b0, we: 1'b1,
                                     wr_inv: 1'b0, exp_inv: 1'b0};
  localparam elem_cfg_t ElemM1   = '{active: 1'b1, up: 1'b1, cmp: 1'b1, we: 1'b1,
                                     wr_inv: 1'b1, exp_inv: 1'b0};
  localparam elem_cfg_t ElemM2   = '{active: 1'b1, up: 1'b0, cmp: 1'b1, we: 1'b1,
                                     wr_inv: 1'b0, exp_inv: 1'b1};
  localparam elem_cfg_t ElemM3   = '{active: 1'b1, up: 1'b1, cmp: 1'b1, we: 1'b0,
                                     wr_inv: 1'b0, exp_inv: 1'b0};

  function automatic elem_cfg_t elem_cfg(input state_e st);
    elem_cfg_t cfg;
    case (st)
      StM0:    cfg = ElemM0;
      StM1:    cfg = ElemM1;
      StM2:    cfg = ElemM2;
      StM3:    cfg = ElemM3;
      default: cfg = ElemNone;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/march_addr_counter.sv
// Up/down address counter for one march element, with load-0 / load-max
// and a flag marking the final address of the element in the current direction.
module march_addr_counter #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned NUM_BYTES = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_zero_i,
  input  logic                 load_max_i,
  input  logic                 step_i,
  input  logic                 up_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 last_o
);

  localparam logic [ADDR_BITS-1:0] MaxAddr = ADDR_BITS'(NUM_BYTES - 1);
  localparam logic [ADDR_BITS-1:0] One     = ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] addr_d, addr_q;

  always_comb begin
    addr_d = addr_q;
    if (load_zero_i) begin
      addr_d = '0;
    end else if (load_max_i) begin
      addr_d = MaxAddr;
    end else if (step_i) begin
      addr_d = up_i ? (addr_q + One) : (addr_q - One);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = up_i ? (addr_q == MaxAddr) : (addr_q == '0);

endmodule

// File: rtl/ram_march_tester.sv
// Four-element march test controller for the on-chip byte RAM.
// RAM-side outputs decode only from registered state, address and pattern.
module ram_march_tester #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned NUM_BYTES = 48,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] pattern_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ADDR_BITS-1:0] fail_addr_o,
  output logic [DATA_BITS-1:0] fail_data_o,
  output logic [DATA_BITS-1:0] fail_exp_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [DATA_BITS-1:0] mem_wdata_o,
  output logic                 mem_we_o,
  input  logic [DATA_BITS-1:0] mem_rdata_i
);

  import ram_march_pkg::*;

  state_e               state_d, state_q;
  logic [DATA_BITS-1:0] pat_d, pat_q;
  logic                 pass_d, pass_q;
  logic [ADDR_BITS-1:0] fail_addr_d, fail_addr_q;
  logic [DATA_BITS-1:0] fail_data_d, fail_data_q;
  logic [DATA_BITS-1:0] fail_exp_d, fail_exp_q;

  elem_cfg_t            cfg;
  logic [DATA_BITS-1:0] exp_data;
  logic                 mismatch;
  logic                 cnt_load_zero, cnt_load_max, cnt_step;
  logic [ADDR_BITS-1:0] addr;
  logic                 addr_last;

  march_addr_counter #(
    .ADDR_BITS(ADDR_BITS),
    .NUM_BYTES(NUM_BYTES)
  ) u_addr_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_zero_i(cnt_load_zero),
    .load_max_i (cnt_load_max),
    .step_i     (cnt_step),
    .up_i       (cfg.up),
    .addr_o     (addr),
    .last_o     (addr_last)
  );

  always_comb begin
    cfg      = elem_cfg(state_q);
    exp_data = cfg.exp_inv ? ~pat_q : pat_q;
    mismatch = cfg.cmp && (mem_rdata_i != exp_data);

    state_d       = state_q;
    pat_d         = pat_q;
    pass_d        = pass_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    fail_exp_d    = fail_exp_q;
    cnt_load_zero = 1'b0;
    cnt_load_max  = 1'b0;
    cnt_step      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          pat_d         = pattern_i;
          pass_d        = 1'b0;
          fail_addr_d   = '0;
          fail_data_d   = '0;
          fail_exp_d    = '0;
          cnt_load_zero = 1'b1;
          state_d       = StM0;
        end
      end
      StM0, StM1, StM2, StM3: begin
        if (mismatch) begin
          // Abort; the write scheduled this cycle still lands in the RAM.
          fail_addr_d = addr;
          fail_data_d = mem_rdata_i;
          fail_exp_d  = exp_data;
          pass_d      = 1'b0;
          state_d     = StDone;
        end else if (addr_last) begin
          case (state_q)
            StM0: begin
              state_d       = StM1;
              cnt_load_zero = 1'b1;
            end
            StM1: begin
              state_d      = StM2;
              cnt_load_max = 1'b1;
            end
            StM2: begin
              state_d       = StM3;
              cnt_load_zero = 1'b1;
            end
            default: begin
              state_d = StDone;
              pass_d  = 1'b1;
            end
          endcase
        end else begin
          cnt_step = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_exp_q  <= fail_exp_d;
    end
  end

  assign busy_o      = cfg.active;
  assign done_o      = (state_q == StDone);
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign fail_exp_o  = fail_exp_q;
  assign mem_addr_o  = cfg.active ? addr : '0;
  assign mem_we_o    = cfg.we;
  assign mem_wdata_o = cfg.we ? (cfg.wr_inv ? ~pat_q : pat_q) : '0;

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: fault-injecting RAM models, table vectors,
// hand-written corner sequences and randomized runs against a march model.
module tb_ram_march_tester;

  localparam int N0 = 48;
  localparam int N1 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1;
  logic [7:0] pattern;

  logic       busy0, done0, pass0, we0;
  logic [5:0] fa0, addr0;
  logic [7:0] fd0, fe0, wd0, rd0;
  logic       busy1, done1, pass1, we1;
  logic [5:0] fa1, addr1;
  logic [7:0] fd1, fe1, wd1, rd1;

  ram_march_tester #(.ADDR_BITS(6), .NUM_BYTES(N0), .DATA_BITS(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .pattern_i(pattern),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_addr_o(fa0),
    .fail_data_o(fd0), .fail_exp_o(fe0), .mem_addr_o(addr0), .mem_wdata_o(wd0),
    .mem_we_o(we0), .mem_rdata_i(rd0)
  );

  ram_march_tester #(.ADDR_BITS(6), .NUM_BYTES(N1), .DATA_BITS(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .pattern_i(pattern),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_addr_o(fa1),
    .fail_data_o(fd1), .fail_exp_o(fe1), .mem_addr_o(addr1), .mem_wdata_o(wd1),
    .mem_we_o(we1), .mem_rdata_i(rd1)
  );

  // Fault configuration shared by the RAM model of dut0 and the reference model
  bit         stuck_en, alias_en;
  logic [5:0] stuck_addr, alias_src, alias_dst;
  logic [2:0] stuck_bit;
  logic       stuck_val;

  logic [7:0] ram0 [64];
  logic [7:0] ram1 [64];
  logic [7:0] ref_mem [64];

  function automatic logic [7:0] stored(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] v;
    v = d;
    if (stuck_en && a == stuck_addr) v[stuck_bit] = stuck_val;
    return v;
  endfunction

  assign rd0 = ram0[addr0];
  assign rd1 = ram1[addr1];

  always @(posedge clk) begin
    if (we0) begin
      ram0[addr0] <= stored(addr0, wd0);
      if (alias_en && addr0 == alias_src) ram0[alias_dst] <= stored(alias_dst, wd0);
    end
    if (we1) ram1[addr1] <= wd1;
  end

  // Selected-DUT view used by the run task
  logic       sel;
  logic       s_busy, s_done, s_pass, s_we;
  logic [5:0] s_addr, s_fa;
  logic [7:0] s_wd, s_fd, s_fe;
  assign s_busy = sel ? busy1 : busy0;
  assign s_done = sel ? done1 : done0;
  assign s_pass = sel ? pass1 : pass0;
  assign s_we   = sel ? we1 : we0;
  assign s_addr = sel ? addr1 : addr0;
  assign s_fa   = sel ? fa1 : fa0;
  assign s_wd   = sel ? wd1 : wd0;
  assign s_fd   = sel ? fd1 : fd0;
  assign s_fe   = sel ? fe1 : fe0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_fault(input int mode, input int a, input int b, input int v,
                           input int dst);
    stuck_en   = (mode == 1);
    alias_en   = (mode == 2);
    stuck_addr = 6'(a);
    stuck_bit  = 3'(b);
    stuck_val  = v[0];
    alias_src  = 6'(a);
    alias_dst  = 6'(dst);
  endtask

  function automatic void ref_wr(input logic [5:0] a, input logic [7:0] d);
    ref_mem[a] = stored(a, d);
    if (alias_en && a == alias_src) ref_mem[alias_dst] = stored(alias_dst, d);
  endfunction

  // March over N0 locations on a plain array: up write P, up read P / write ~P,
  // down read ~P / write P, up read P. Stops at the first wrong read.
  task automatic ref_march(input logic [7:0] p, output bit ok, output int fa,
                           output int fd, output int fe, output int cyc);
    logic [7:0] np;
    logic [5:0] ai;
    np = ~p; ok = 1'b1; fa = 0; fd = 0; fe = 0; cyc = 0;
    for (int a = 0; a < N0; a++) begin
      ai = 6'(a); cyc++; ref_wr(ai, p);
    end
    for (int a = 0; a < N0; a++) begin
      ai = 6'(a); cyc++;
      if (ref_mem[ai] != p) begin ok = 0; fa = a; fd = ref_mem[ai]; fe = p; return; end
      ref_wr(ai, np);
    end
    for (int a = N0 - 1; a >= 0; a--) begin
      ai = 6'(a); cyc++;
      if (ref_mem[ai] != np) begin ok = 0; fa = a; fd = ref_mem[ai]; fe = np; return; end
      ref_wr(ai, p);
    end
    for (int a = 0; a < N0; a++) begin
      ai = 6'(a); cyc++;
      if (ref_mem[ai] != p) begin ok = 0; fa = a; fd = ref_mem[ai]; fe = p; return; end
    end
  endtask

  // Starts a run from IDLE and follows it to the DONE cycle, checking the
  // per-cycle address/write sequence. Returns positioned at the DONE negedge.
  task automatic run_march(input bit inst, input logic [7:0] p, input bit hold,
                           output bit r_pass, output int r_fa, output int r_fd,
                           output int r_fe, output int r_busy, output int r_we);
    int n, k, seq_err, e, i, ea, limit;
    n = inst ? N1 : N0;
    sel = inst;
    pattern = p;
    if (inst) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    k = 1; seq_err = 0; r_busy = 0; r_we = 0; limit = 4 * n + 4;
    while (!s_done && k <= limit) begin
      if (!s_busy) seq_err++;
      else begin
        r_busy++;
        e  = (k - 1) / n;
        i  = (k - 1) % n;
        ea = (e == 2) ? (n - 1 - i) : i;
        if (int'(s_addr) != ea) seq_err++;
        if (s_we != (e < 3)) seq_err++;
        if (s_we && s_wd != ((e == 1) ? ~p : p)) seq_err++;
      end
      if (s_we) r_we++;
      @(negedge clk);
      k++;
    end
    check("done_seen", int'(s_done), 1);
    check("addr_we_sequence", seq_err, 0);
    check("busy_in_done", int'(s_busy), 0);
    check("mem_idle_in_done", int'({s_we, s_addr, s_wd}), 0);
    r_pass = s_pass; r_fa = s_fa; r_fd = s_fd; r_fe = s_fe;
  endtask

  typedef struct {
    logic [7:0] p;
    int mode, fa_addr, fa_bit, fa_val, dst;
    bit exp_pass;
    int exp_fa, exp_fd, exp_fe, exp_busy, exp_we;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    bit   r_pass, m_pass;
    int   r_fa, r_fd, r_fe, r_busy, r_we, m_fa, m_fd, m_fe, m_cyc, k, mode;
    logic [7:0] p;

    vecs[0] = '{8'h55, 0, 0, 0, 0, 0, 1'b1, 0, 0, 0, 192, 144};
    vecs[1] = '{8'h55, 1, 17, 3, 0, 0, 1'b0, 17, 'hA2, 'hAA, 127, 127};
    vecs[2] = '{8'h55, 2, 5, 0, 0, 6, 1'b0, 6, 'hAA, 'h55, 55, 55};
    vecs[3] = '{8'hF0, 0, 0, 0, 0, 0, 1'b1, 0, 0, 0, 192, 144};
    vecs[4] = '{8'h00, 1, 0, 0, 1, 0, 1'b0, 0, 'h01, 'h00, 49, 49};
    vecs[5] = '{8'hFF, 1, 47, 7, 0, 0, 1'b0, 47, 'h7F, 'hFF, 96, 96};
    vecs[6] = '{8'h0F, 2, 10, 0, 0, 3, 1'b0, 3, 'h0F, 'hF0, 141, 141};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; pattern = 8'h00; sel = 1'b0;
    set_fault(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset_ctrl", int'({busy0, done0, pass0, we0}), 0);
    check("reset_fail", int'({fa0, fd0, fe0}), 0);
    check("reset_mem", int'({addr0, wd0}), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      set_fault(vecs[v].mode, vecs[v].fa_addr, vecs[v].fa_bit, vecs[v].fa_val, vecs[v].dst);
      run_march(1'b0, vecs[v].p, 1'b0, r_pass, r_fa, r_fd, r_fe, r_busy, r_we);
      check($sformatf("vec%0d_pass", v), int'(r_pass), int'(vecs[v].exp_pass));
      check($sformatf("vec%0d_fail_addr", v), r_fa, vecs[v].exp_fa);
      check($sformatf("vec%0d_fail_data", v), r_fd, vecs[v].exp_fd);
      check($sformatf("vec%0d_fail_exp", v), r_fe, vecs[v].exp_fe);
      check($sformatf("vec%0d_busy_cycles", v), r_busy, vecs[v].exp_busy);
      check($sformatf("vec%0d_we_cycles", v), r_we, vecs[v].exp_we);
      @(negedge clk);
      check($sformatf("vec%0d_result_held", v), int'({pass0, fa0, fd0, fe0}),
            int'({vecs[v].exp_pass, 6'(vecs[v].exp_fa), 8'(vecs[v].exp_fd),
                  8'(vecs[v].exp_fe)}));
    end
    set_fault(0, 0, 0, 0, 0);

    // start held high across a whole run and into the following IDLE
    run_march(1'b0, 8'h33, 1'b1, r_pass, r_fa, r_fd, r_fe, r_busy, r_we);
    check("hold_pass", int'(r_pass), 1);
    check("hold_busy_cycles", r_busy, 192);
    @(negedge clk);
    check("hold_idle_busy_done", int'({busy0, done0}), 0);
    check("hold_idle_pass", int'(pass0), 1);
    @(negedge clk);
    check("hold_reaccept_busy", int'(busy0), 1);
    check("hold_pass_cleared", int'(pass0), 0);
    start0 = 1'b0;
    k = 0;
    while (!done0 && k < 300) begin @(negedge clk); k++; end
    check("hold_second_done", int'(done0), 1);
    @(negedge clk);

    // reset during M2 at address 30
    pattern = 8'h55; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int c = 1; c < 114; c++) @(negedge clk);
    check("m2_addr30_reached", int'({busy0, we0, addr0, wd0}), int'({1'b1, 1'b1, 6'd30, 8'h55}));
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_ctrl", int'({busy0, done0, pass0, we0}), 0);
    check("midrun_reset_fail", int'({fa0, fd0, fe0}), 0);
    check("midrun_reset_mem", int'({addr0, wd0}), 0);
    rst = 1'b0;
    @(negedge clk);
    run_march(1'b0, 8'hF0, 1'b0, r_pass, r_fa, r_fd, r_fe, r_busy, r_we);
    check("after_reset_pass", int'(r_pass), 1);
    check("after_reset_busy", r_busy, 192);
    @(negedge clk);

    // full 64-location variant
    run_march(1'b1, 8'($urandom), 1'b0, r_pass, r_fa, r_fd, r_fe, r_busy, r_we);
    check("n64_pass", int'(r_pass), 1);
    check("n64_busy_cycles", r_busy, 256);
    check("n64_we_cycles", r_we, 192);
    @(negedge clk);

    // randomized faults against the march model
    for (int t = 0; t < 16; t++) begin
      mode = $urandom_range(2, 0);
      k = $urandom_range(N0 - 1, 0);
      m_fa = (k + 1 + $urandom_range(N0 - 2, 0)) % N0;
      set_fault(mode, k, $urandom_range(7, 0), $urandom_range(1, 0), m_fa);
      p = 8'($urandom);
      ref_march(p, m_pass, m_fa, m_fd, m_fe, m_cyc);
      run_march(1'b0, p, 1'b0, r_pass, r_fa, r_fd, r_fe, r_busy, r_we);
      check($sformatf("rnd%0d_pass", t), int'(r_pass), int'(m_pass));
      check($sformatf("rnd%0d_fail", t), int'({6'(r_fa), 8'(r_fd), 8'(r_fe)}),
            int'({6'(m_fa), 8'(m_fd), 8'(m_fe)}));
      check($sformatf("rnd%0d_busy", t), r_busy, m_cyc);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
